// File: rtl/ps2_key_event_decoder.sv
// rtl/ps2_key_event_decoder.sv - PS/2 Set-2 scan-code parser, key table match and event FIFO
// Event FIFO is first-word fall-through; a pop frees a slot for a push in the same cycle.
module ps2_evt_fifo #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 4
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge CLOCK_50) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

module ps2_key_event_decoder #(
  parameter int                    NUM_KEYS       = 3,
  parameter logic [8*NUM_KEYS-1:0] KEY_CODES      = 24'h23_1B_33,
  parameter logic [NUM_KEYS-1:0]   EXT_MASK       = 3'b000,
  parameter bit                    REPEAT_FILTER  = 1'b1,
  parameter bit                    REPORT_RELEASE = 1'b1,
  parameter int                    FIFO_DEPTH     = 4,
  localparam int                   KW             = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic [7:0]          rx_data,
  input  logic                rx_data_en,
  output logic [NUM_KEYS-1:0] key_pulse,
  output logic [NUM_KEYS-1:0] key_held,
  output logic                evt_valid,
  output logic                evt_release,
  output logic [KW-1:0]       evt_key,
  input  logic                evt_ready,
  output logic                overflow,
  output logic [7:0]          last_code
);
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXT,
    ST_BREAK,
    ST_EXT_BREAK,
    ST_SKIP
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [2:0]          skip_cnt;
  logic [2:0]          skip_cnt_nxt;
  logic                is_discard;
  logic                code_strobe;
  logic                code_ext;
  logic                code_release;
  logic                hit;
  logic [KW-1:0]       hit_idx;
  logic [NUM_KEYS-1:0] held_nxt;
  logic [NUM_KEYS-1:0] pulse_nxt;
  logic                push;
  logic                push_rel;
  logic                pop;
  logic                fifo_full;
  logic                fifo_empty;
  logic [KW:0]         fifo_head;

  assign is_discard = (rx_data == 8'h00) || (rx_data == 8'hAA) || (rx_data == 8'hEE) ||
                      (rx_data == 8'hFA) || (rx_data == 8'hFE) || (rx_data == 8'hFF);

  always_comb begin
    state_nxt    = state;
    skip_cnt_nxt = skip_cnt;
    code_strobe  = 1'b0;
    code_ext     = 1'b0;
    code_release = 1'b0;
    if (rx_data_en) begin
      if (state == ST_SKIP) begin
        // Pause sequence payload is swallowed byte by byte, discard codes included.
        if (skip_cnt <= 3'd1) begin
          skip_cnt_nxt = 3'd0;
          state_nxt    = ST_IDLE;
        end else begin
          skip_cnt_nxt = skip_cnt - 3'd1;
        end
      end else if (is_discard) begin
        state_nxt = ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (rx_data == 8'hE0) begin
              state_nxt = ST_EXT;
            end else if (rx_data == 8'hF0) begin
              state_nxt = ST_BREAK;
            end else if (rx_data == 8'hE1) begin
              state_nxt    = ST_SKIP;
              skip_cnt_nxt = 3'd7;
            end else begin
              code_strobe = 1'b1;
            end
          end
          ST_EXT: begin
            if (rx_data == 8'hF0) begin
              state_nxt = ST_EXT_BREAK;
            end else if (rx_data != 8'hE0) begin
              code_strobe = 1'b1;
              code_ext    = 1'b1;
              state_nxt   = ST_IDLE;
            end
          end
          ST_BREAK: begin
            if ((rx_data != 8'hE0) && (rx_data != 8'hF0)) begin
              code_strobe  = 1'b1;
              code_release = 1'b1;
              state_nxt    = ST_IDLE;
            end
          end
          ST_EXT_BREAK: begin
            if ((rx_data != 8'hE0) && (rx_data != 8'hF0)) begin
              code_strobe  = 1'b1;
              code_release = 1'b1;
              code_ext     = 1'b1;
              state_nxt    = ST_IDLE;
            end
          end
          default: state_nxt = ST_IDLE;
        endcase
      end
    end
  end

  // Scan from the top so the lowest matching index is the one left standing.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if ((rx_data == KEY_CODES[8*i +: 8]) && (code_ext == EXT_MASK[i])) begin
        hit     = 1'b1;
        hit_idx = KW'(i);
      end
    end
  end

  always_comb begin
    held_nxt  = key_held;
    pulse_nxt = '0;
    push      = 1'b0;
    push_rel  = 1'b0;
    if (code_strobe && hit) begin
      if (!code_release) begin
        if (!key_held[hit_idx] || !REPEAT_FILTER) begin
          pulse_nxt[hit_idx] = 1'b1;
          push               = 1'b1;
        end
        held_nxt[hit_idx] = 1'b1;
      end else if (key_held[hit_idx]) begin
        held_nxt[hit_idx] = 1'b0;
        push              = REPORT_RELEASE;
        push_rel          = 1'b1;
      end
    end
  end

  assign pop = evt_valid && evt_ready;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state     <= ST_IDLE;
      skip_cnt  <= 3'd0;
      key_held  <= '0;
      key_pulse <= '0;
      last_code <= 8'h00;
      overflow  <= 1'b0;
    end else begin
      state     <= state_nxt;
      skip_cnt  <= skip_cnt_nxt;
      key_held  <= held_nxt;
      key_pulse <= pulse_nxt;
      if (code_strobe) begin
        last_code <= rx_data;
      end
      if (push && fifo_full && !pop) begin
        overflow <= 1'b1;
      end
    end
  end

  ps2_evt_fifo #(
    .WIDTH (KW + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_evt_fifo (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .push      (push),
    .push_data ({push_rel, hit_idx}),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

  // Head fields read as zero while empty so the reset state is clean.
  assign evt_valid   = !fifo_empty;
  assign evt_release = evt_valid && fifo_head[KW];
  assign evt_key     = evt_valid ? fifo_head[KW-1:0] : '0;
endmodule

// File: doc/ps2_key_event_decoder.md
# ps2_key_event_decoder

Parametrised PS/2 scan-code decoder that sits between `PS2_Controller` and the game FSM. It parses the Set-2 byte stream, including E0 extended prefixes, F0 break prefixes and the E1 Pause sequence, and matches codes against a configurable key table. For each key it tracks the held state, suppresses typematic repeats, and emits make pulses. It also queues make/release events in a small FIFO with a valid/ready handshake.

## Interface
- `NUM_KEYS`, 3: number of mapped keys, 1..16.
- `KEY_CODES`, 24'h23_1B_33: packed scan codes; key i = bits [8i+7:8i]. Default: key0=0x33 (H), key1=0x1B (S), key2=0x23 (D).
- `EXT_MASK`, 3'b000: bit i=1 means key i requires the E0 prefix.
- `REPEAT_FILTER`, 1: when 1, a make for an already-held key produces no pulse and no event.
- `REPORT_RELEASE`, 1: when 1, releases are pushed to the FIFO.
- `FIFO_DEPTH`, 4: event FIFO entries; power of two, ≥2.
- Localparam `KW` = max(1, clog2(NUM_KEYS)).
- `CLOCK_50` in 1: sole clock, all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `rx_data` in 8: received byte from `PS2_Controller`.
- `rx_data_en` in 1: one-cycle strobe, `rx_data` valid.
- `key_pulse` out NUM_KEYS: one-cycle pulse per accepted make.
- `key_held` out NUM_KEYS: level, key currently down.
- `evt_valid` out 1: FIFO head valid (first-word fall-through).
- `evt_release` out 1: head event is a release (0 = make).
- `evt_key` out KW: head event key index.
- `evt_ready` in 1: consumer pop; a pop occurs when `evt_valid && evt_ready`.
- `overflow` out 1: sticky; an event was dropped because the FIFO was full.
- `last_code` out 8: last non-prefix byte accepted (debug LEDs).

## Operation
- Parser FSM states: IDLE, EXT, BREAK, EXT_BREAK, SKIP. All transitions occur only on `rx_data_en`.
- Discard set {0x00, 0xAA, 0xEE, 0xFA, 0xFE, 0xFF}: in any state except SKIP, the byte is ignored and the FSM goes to IDLE. `last_code` is unchanged.
- IDLE:
  - E0 → EXT.
  - F0 → BREAK.
  - E1 → SKIP with skip counter = 7.
  - Any other byte → make(code, ext=0).
- EXT:
  - F0 → EXT_BREAK.
  - E0 → stay in EXT.
  - Any other byte → make(code, ext=1), then IDLE.
- BREAK:
  - E0/F0 → stay in BREAK.
  - Any other byte → release(code, ext=0), then IDLE.
- EXT_BREAK:
  - E0/F0 → stay in EXT_BREAK.
  - Any other byte → release(code, ext=1), then IDLE.
- SKIP: each byte (discard set included) decrements the counter; at 0 → IDLE. No key effects.
- Match: key i matches when `code == KEY_CODES[i]` and `ext == EXT_MASK[i]`. If several keys match, the lowest index wins. Unmatched codes update `last_code` only.
- Make on key i:
  - If `!key_held[i] || !REPEAT_FILTER`: pulse `key_pulse[i]` and push {0, i}.
  - Then set `key_held[i]`.
- Release on key i:
  - If `key_held[i]`: clear it and push {1, i} when `REPORT_RELEASE`.
  - If the key is not held, the release is ignored entirely.
- FIFO:
  - Push when full and no simultaneous pop: the event is dropped and `overflow` is set. `key_pulse`/`key_held` still update.
  - Push and pop in the same cycle: both succeed, including when full.
  - Pop when empty: no effect.
- Reset mid-sequence (e.g. after E0 or F0, or within SKIP) → IDLE. A following plain code is treated as a make.

## Timing
- Reset values:
  - All outputs 0: `key_pulse`, `key_held`, `evt_valid`, `evt_release`, `evt_key`, `overflow`, `last_code`.
  - FSM in IDLE, skip counter 0, FIFO empty.
- Latency: a strobe sampled at edge N produces `key_pulse`/`key_held`/`last_code` changes visible after edge N (cycle N+1). `key_pulse` is high for exactly one cycle.
- Event pushed into an empty FIFO: `evt_valid` rises in the same cycle as the corresponding `key_pulse`.
- Pop at edge M: the next entry is presented after edge M; `evt_valid` drops if the FIFO is now empty.
- `evt_key`/`evt_release` are stable while `evt_valid && !evt_ready`.
- Back-to-back strobes on consecutive cycles are accepted; each byte is processed independently.

## Test plan
- Defaults. Bytes 33, F0, 33 → `key_pulse[0]` for 1 cycle, `key_held` 001 then 000. FIFO holds {0,0},{1,0}. `last_code` = 0x33.
- Typematic repeat. Bytes 1B,1B,1B, F0,1B → exactly one `key_pulse[1]`, FIFO holds 2 events. With REPEAT_FILTER=0 → three pulses, 4 events.
- Extended key. KEY_CODES[0]=0x75, EXT_MASK=001 (up arrow). Bytes E0,75 → pulse[0]. Bare 75 → no pulse, `last_code` = 0x75. E0,F0,75 → `key_held[0]` clears.
- Pause sequence. Bytes E1,14,77,E1,F0,14,F0,77, then 23 → no pulses during the sequence. Then `key_pulse[2]`, FSM in IDLE.
- FIFO full. `evt_ready`=0, FIFO_DEPTH=4. Makes/releases on keys 0,1,2 produce 6 events → first 4 retained, `overflow`=1, `key_held` correct. Then hold `evt_ready`=1 for 4 cycles → entries pop in order and `evt_valid` = 0. Full FIFO with a push and pop in the same cycle → no drop.
- Reset and discard. Bytes F0, then reset, then 33 → make (pulse[0]). Byte AA while in BREAK → return to IDLE, then 1B is a make.
